// File: rtl/core_data_mem_responder.sv
// Data-side memory responder for a req/gnt/rvalid core bus: word-addressed
// array with byte-enable writes, RISC-V AMOs, LR/SC and fixed response latency.
module core_data_mem_responder #(
  parameter int unsigned DEPTH     = 1024,
  parameter int unsigned LATENCY   = 1,
  parameter logic [31:0] BASE_ADDR = 32'h1000_0000,
  parameter logic [31:0] OOR_RDATA = 32'hDEAD_BEEF
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        data_req_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic [31:0] data_rdata_o,
  input  logic [5:0]  data_atop_i,
  input  logic        stall_i
);

  localparam int unsigned IDXW = $clog2(DEPTH);
  localparam logic [32:0] SPAN = 33'(DEPTH) << 2;

  localparam logic [4:0] AMO_ADD  = 5'b00000;
  localparam logic [4:0] AMO_SWAP = 5'b00001;
  localparam logic [4:0] AMO_LR   = 5'b00010;
  localparam logic [4:0] AMO_SC   = 5'b00011;
  localparam logic [4:0] AMO_XOR  = 5'b00100;
  localparam logic [4:0] AMO_OR   = 5'b01000;
  localparam logic [4:0] AMO_AND  = 5'b01100;
  localparam logic [4:0] AMO_MIN  = 5'b10000;
  localparam logic [4:0] AMO_MAX  = 5'b10100;
  localparam logic [4:0] AMO_MINU = 5'b11000;
  localparam logic [4:0] AMO_MAXU = 5'b11100;

  logic [31:0]      mem_q [DEPTH];
  logic             rsv_vld_q, rsv_vld_d;
  logic [IDXW-1:0]  rsv_idx_q, rsv_idx_d;
  logic [LATENCY-1:0] vld_q;
  logic [31:0]      dat_q [LATENCY];

  logic [31:0]      offset;
  logic             in_range;
  logic [IDXW-1:0]  idx;
  logic [31:0]      old_word, new_word, resp_d;
  logic             mem_we;
  logic             rsv_hit;

  assign data_gnt_o = data_req_i & ~stall_i;
  assign offset     = data_addr_i - BASE_ADDR;
  assign in_range   = (data_addr_i >= BASE_ADDR) && ({1'b0, offset} < SPAN);
  assign idx        = offset[IDXW+1:2];
  assign old_word   = mem_q[idx];
  assign rsv_hit    = rsv_vld_q && (rsv_idx_q == idx);

  always_comb begin
    new_word  = old_word;
    mem_we    = 1'b0;
    resp_d    = old_word;
    rsv_vld_d = rsv_vld_q;
    rsv_idx_d = rsv_idx_q;
    if (!in_range) begin
      resp_d = OOR_RDATA;
    end else if (data_atop_i[5]) begin
      case (data_atop_i[4:0])
        AMO_ADD:  begin new_word = old_word + data_wdata_i; mem_we = 1'b1; end
        AMO_SWAP: begin new_word = data_wdata_i;            mem_we = 1'b1; end
        AMO_XOR:  begin new_word = old_word ^ data_wdata_i; mem_we = 1'b1; end
        AMO_AND:  begin new_word = old_word & data_wdata_i; mem_we = 1'b1; end
        AMO_OR:   begin new_word = old_word | data_wdata_i; mem_we = 1'b1; end
        AMO_MIN:  begin
          new_word = ($signed(old_word) < $signed(data_wdata_i)) ? old_word : data_wdata_i;
          mem_we   = 1'b1;
        end
        AMO_MAX:  begin
          new_word = ($signed(old_word) > $signed(data_wdata_i)) ? old_word : data_wdata_i;
          mem_we   = 1'b1;
        end
        AMO_MINU: begin
          new_word = (old_word < data_wdata_i) ? old_word : data_wdata_i;
          mem_we   = 1'b1;
        end
        AMO_MAXU: begin
          new_word = (old_word > data_wdata_i) ? old_word : data_wdata_i;
          mem_we   = 1'b1;
        end
        AMO_LR:   begin rsv_vld_d = 1'b1; rsv_idx_d = idx; end
        AMO_SC:   begin
          rsv_vld_d = 1'b0;
          if (rsv_hit) begin
            new_word = data_wdata_i;
            mem_we   = 1'b1;
            resp_d   = '0;
          end else begin
            resp_d = 32'd1;
          end
        end
        default: ;
      endcase
      // Any storing AMO (including a successful SC) kills a matching reservation.
      if (mem_we && rsv_hit) rsv_vld_d = 1'b0;
    end else if (data_we_i) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (data_be_i[b]) new_word[8*b +: 8] = data_wdata_i[8*b +: 8];
      end
      mem_we = 1'b1;
      resp_d = '0;
      if (rsv_hit) rsv_vld_d = 1'b0;
    end
  end

  // Storage is deliberately outside the reset domain so contents survive reset.
  always_ff @(posedge clk_i) begin
    if (data_gnt_o && mem_we) mem_q[idx] <= new_word;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rsv_vld_q <= 1'b0;
      rsv_idx_q <= '0;
    end else if (data_gnt_o) begin
      rsv_vld_q <= rsv_vld_d;
      rsv_idx_q <= rsv_idx_d;
    end
  end

  // Data stages only load on a valid entry, so the last stage holds its value.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld_q <= '0;
      for (int unsigned i = 0; i < LATENCY; i++) dat_q[i] <= '0;
    end else begin
      vld_q[0] <= data_gnt_o;
      if (data_gnt_o) dat_q[0] <= resp_d;
      for (int unsigned i = 1; i < LATENCY; i++) begin
        vld_q[i] <= vld_q[i-1];
        if (vld_q[i-1]) dat_q[i] <= dat_q[i-1];
      end
    end
  end

  assign data_rvalid_o = vld_q[LATENCY-1];
  assign data_rdata_o  = dat_q[LATENCY-1];

endmodule

// File: tb/tb_core_data_mem_responder.sv
// Randomized bench for core_data_mem_responder: two instances (LATENCY 1 and 3)
// share stimulus and are checked against an operation-level memory model.
module tb_core_data_mem_responder;

  localparam int unsigned DEPTH = 16;
  localparam logic [31:0] BASE  = 32'h1000_0000;
  localparam logic [31:0] OOR   = 32'hDEAD_BEEF;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        req = 1'b0, stall = 1'b0, we = 1'b0;
  logic [3:0]  be = '0;
  logic [31:0] addr = '0, wdata = '0;
  logic [5:0]  atop = '0;
  logic        gnt1, gnt3, rv1, rv3;
  logic [31:0] rd1, rd3;

  always #5 clk_i = ~clk_i;

  core_data_mem_responder #(.DEPTH(DEPTH), .LATENCY(1), .BASE_ADDR(BASE), .OOR_RDATA(OOR)) dut1 (
    .clk_i(clk_i), .rst_i(rst_i), .data_req_i(req), .data_gnt_o(gnt1),
    .data_rvalid_o(rv1), .data_we_i(we), .data_be_i(be), .data_addr_i(addr),
    .data_wdata_i(wdata), .data_rdata_o(rd1), .data_atop_i(atop), .stall_i(stall)
  );

  core_data_mem_responder #(.DEPTH(DEPTH), .LATENCY(3), .BASE_ADDR(BASE), .OOR_RDATA(OOR)) dut3 (
    .clk_i(clk_i), .rst_i(rst_i), .data_req_i(req), .data_gnt_o(gnt3),
    .data_rvalid_o(rv3), .data_we_i(we), .data_be_i(be), .data_addr_i(addr),
    .data_wdata_i(wdata), .data_rdata_o(rd3), .data_atop_i(atop), .stall_i(stall)
  );

  typedef struct {
    int          due;
    logic [31:0] d;
  } resp_t;

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  int          stall_mode = 0;
  logic [31:0] mem_m [DEPTH];
  bit          rsv_v = 1'b0;
  int unsigned rsv_i = 0;
  resp_t       q1[$];
  resp_t       q3[$];
  logic [31:0] last1 = '0, last3 = '0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Reference: one whole bus operation applied to the word array.
  task automatic model_op(input logic w, input logic [3:0] b, input logic [31:0] a,
                          input logic [31:0] d, input logic [5:0] t, output logic [31:0] r);
    int unsigned ix;
    logic [31:0] old, nw;
    bit wr;
    if (a < BASE || (a - BASE) >= 4 * DEPTH) begin
      r = OOR;
      return;
    end
    ix  = (a - BASE) / 4;
    old = mem_m[ix];
    nw  = old;
    wr  = 1'b0;
    r   = old;
    if (t[5]) begin
      case (t[4:0])
        5'b00000: begin nw = old + d; wr = 1'b1; end
        5'b00001: begin nw = d;       wr = 1'b1; end
        5'b00100: begin nw = old ^ d; wr = 1'b1; end
        5'b01100: begin nw = old & d; wr = 1'b1; end
        5'b01000: begin nw = old | d; wr = 1'b1; end
        5'b10000: begin nw = ($signed(old) <= $signed(d)) ? old : d; wr = 1'b1; end
        5'b10100: begin nw = ($signed(old) >= $signed(d)) ? old : d; wr = 1'b1; end
        5'b11000: begin nw = (old <= d) ? old : d; wr = 1'b1; end
        5'b11100: begin nw = (old >= d) ? old : d; wr = 1'b1; end
        5'b00010: begin rsv_v = 1'b1; rsv_i = ix; end
        5'b00011: begin
          if (rsv_v && rsv_i == ix) begin
            mem_m[ix] = d;
            r = 32'd0;
          end else begin
            r = 32'd1;
          end
          rsv_v = 1'b0;
        end
        default: ;
      endcase
    end else if (w) begin
      for (int k = 0; k < 4; k++) if (b[k]) nw[8*k +: 8] = d[8*k +: 8];
      wr = 1'b1;
      r  = 32'd0;
    end
    if (wr) begin
      mem_m[ix] = nw;
      if (rsv_i == ix) rsv_v = 1'b0;
    end
  endtask

  task automatic set_stall();
    case (stall_mode)
      1:       stall = ($urandom_range(0, 99) < 30);
      2:       stall = ~stall;
      default: stall = 1'b0;
    endcase
  endtask

  // One clock cycle: check outputs at negedge, advance model, re-drive after posedge.
  task automatic step();
    bit e1, e3;
    logic [31:0] r;
    @(negedge clk_i);
    cyc++;
    check_eq("gnt_L1", 32'(gnt1), 32'(req & ~stall));
    check_eq("gnt_L3", 32'(gnt3), 32'(req & ~stall));
    if (rst_i) begin
      q1.delete();
      q3.delete();
      last1 = '0;
      last3 = '0;
      rsv_v = 1'b0;
    end
    e1 = (q1.size() > 0) && (q1[0].due == cyc);
    if (e1) begin last1 = q1[0].d; void'(q1.pop_front()); end
    e3 = (q3.size() > 0) && (q3[0].due == cyc);
    if (e3) begin last3 = q3[0].d; void'(q3.pop_front()); end
    check_eq("rvalid_L1", 32'(rv1), 32'(e1));
    check_eq("rdata_L1", rd1, last1);
    check_eq("rvalid_L3", 32'(rv3), 32'(e3));
    check_eq("rdata_L3", rd3, last3);
    if (!rst_i && req && !stall) begin
      model_op(we, be, addr, wdata, atop, r);
      q1.push_back('{due: cyc + 1, d: r});
      q3.push_back('{due: cyc + 3, d: r});
    end
    @(posedge clk_i);
    #1;
    set_stall();
  endtask

  task automatic issue(input logic w, input logic [3:0] b, input logic [31:0] a,
                       input logic [31:0] d, input logic [5:0] t);
    bit g;
    int waited;
    waited = 0;
    req = 1'b1; we = w; be = b; addr = a; wdata = d; atop = t;
    forever begin
      g = !stall;
      step();
      if (g || waited > 64) break;
      waited++;
    end
    check_eq("grant_wait", 32'(g), 32'd1);
    req = 1'b0;
  endtask

  task automatic idle(input int n);
    req = 1'b0;
    repeat (n) step();
  endtask

  task automatic reset_dut(input int n);
    req   = 1'b0;
    rst_i = 1'b1;
    repeat (n) step();
    rst_i = 1'b0;
  endtask

  task automatic rand_op();
    logic [4:0] fl [12];
    logic [31:0] a;
    int r, kind;
    fl = '{5'b00000, 5'b00001, 5'b00100, 5'b01100, 5'b01000, 5'b10000,
           5'b10100, 5'b11000, 5'b11100, 5'b00010, 5'b00011, 5'b00101};
    r = $urandom_range(0, 99);
    if (r < 3)       a = $urandom;
    else if (r < 6)  a = BASE + 4 * DEPTH + $urandom_range(0, 7);
    else if (r < 9)  a = BASE - 1 - $urandom_range(0, 3);
    else if (r < 55) a = BASE + 4 * $urandom_range(0, 3) + $urandom_range(0, 3);
    else             a = BASE + 4 * $urandom_range(0, DEPTH - 1) + $urandom_range(0, 3);
    kind = $urandom_range(0, 2);
    case (kind)
      0:       issue(1'b0, 4'($urandom), a, $urandom, {1'b0, 5'($urandom)});
      1:       issue(1'b1, 4'($urandom), a, $urandom, {1'b0, 5'($urandom)});
      default: issue(1'($urandom), 4'($urandom), a,
                     ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 3)),
                     {1'b1, fl[$urandom_range(0, 11)]});
    endcase
  endtask

  initial begin
    logic [31:0] a;
    @(posedge clk_i);
    #1;
    reset_dut(2);

    for (int i = 0; i < DEPTH; i++) issue(1'b1, 4'hF, BASE + 4 * i, $urandom, 6'h00);

    a = 32'h1000_0010;
    issue(1'b1, 4'hF, a, 32'h1122_3344, 6'h00);
    issue(1'b0, 4'hF, a, 32'h0, 6'h00);
    issue(1'b1, 4'b0101, a, 32'hAABB_CCDD, 6'h00);
    issue(1'b0, 4'h0, a, 32'h0, 6'h00);

    stall_mode = 2;
    for (int i = 0; i < 4; i++) issue(1'b0, 4'hF, BASE + 4 * i, 32'h0, 6'h00);
    stall_mode = 0;
    stall = 1'b0;
    idle(4);

    a = BASE + 32'h20;
    issue(1'b1, 4'hF, a, 32'hFFFF_FFFE, 6'h00);
    issue(1'b0, 4'h0, a, 32'd5, 6'h20);
    issue(1'b0, 4'hF, a, 32'h0, 6'h00);
    issue(1'b1, 4'hF, a, 32'hFFFF_FFFF, 6'h00);
    issue(1'b0, 4'h0, a, 32'd1, 6'h30);
    issue(1'b0, 4'hF, a, 32'h0, 6'h00);
    issue(1'b1, 4'hF, a, 32'hFFFF_FFFF, 6'h00);
    issue(1'b0, 4'h0, a, 32'd1, 6'h38);
    issue(1'b0, 4'hF, a, 32'h0, 6'h00);

    issue(1'b0, 4'h0, a, 32'h0, 6'h22);
    issue(1'b0, 4'h0, a, 32'd7, 6'h23);
    issue(1'b0, 4'hF, a, 32'h0, 6'h00);
    issue(1'b0, 4'h0, a, 32'h0, 6'h22);
    issue(1'b1, 4'hF, a, 32'h55, 6'h00);
    issue(1'b0, 4'h0, a, 32'd9, 6'h23);
    issue(1'b0, 4'hF, a, 32'h0, 6'h00);

    issue(1'b0, 4'hF, 32'h0000_0000, 32'h0, 6'h00);
    issue(1'b0, 4'hF, BASE + 4 * DEPTH, 32'h0, 6'h00);
    issue(1'b0, 4'hF, BASE - 4, 32'h0, 6'h00);
    issue(1'b1, 4'hF, BASE - 4, 32'h1234, 6'h00);
    issue(1'b0, 4'hF, BASE + 4 * DEPTH - 1, 32'h0, 6'h00);
    idle(3);

    issue(1'b0, 4'hF, 32'h1000_0010, 32'h0, 6'h00);
    reset_dut(1);
    issue(1'b0, 4'hF, BASE + 4, 32'h0, 6'h00);
    issue(1'b0, 4'hF, BASE + 8, 32'h0, 6'h00);
    reset_dut(1);
    idle(3);
    issue(1'b0, 4'hF, 32'h1000_0010, 32'h0, 6'h00);
    issue(1'b0, 4'hF, BASE + 32'h20, 32'h0, 6'h00);
    idle(4);

    stall_mode = 1;
    for (int i = 0; i < 700; i++) begin
      if ($urandom_range(0, 99) < 15) idle(1);
      else rand_op();
    end
    stall_mode = 0;
    idle(6);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
